led_scan_ctrl: RTL and testbench

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

---
 rtl/led_scan_ctrl.sv | 96 +++++++++
 tb/tb_led_scan_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: multiplexed LED digit scanner with 16-step per-digit PWM brightness.
module led_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 8,
  parameter int PRESCALE   = 1000
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        enable,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
  input  logic [3:0]                  brightness,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic [SEG_W-1:0]            seg_out,
  output logic                        frame_start,
  output logic                        busy
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(PRESCALE);
  typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} state_t;
  state_t                        r_state, w_state;
  logic [PW-1:0]                 r_pcnt, w_pcnt;
  logic [3:0]                    r_scnt, w_scnt;
  logic [IW-1:0]                 r_idx, w_idx;
  logic [NUM_DIGITS*SEG_W-1:0]   r_seg_q, w_seg_q;
  logic [3:0]                    r_bright, w_bright;
  logic [NUM_DIGITS-1:0]         r_dsel, w_dsel;
  logic [SEG_W-1:0]              r_seg, w_seg;
  logic                          r_fs, w_fs;
  always_comb begin
    w_state  = r_state;
    w_pcnt   = r_pcnt;
    w_scnt   = r_scnt;
    w_idx    = r_idx;
    w_seg_q  = r_seg_q;
    w_bright = r_bright;
    if (!enable) begin
      w_state = IDLE;
      w_pcnt  = '0;
      w_scnt  = '0;
      w_idx   = '0;
    end else if (r_state == IDLE) begin
      w_state  = BLANK;
      w_pcnt   = '0;
      w_scnt   = '0;
      w_idx    = '0;
      w_seg_q  = seg_data;
      w_bright = brightness;
    end else if (r_pcnt == PW'(PRESCALE - 1)) begin
      w_pcnt = '0;
      w_scnt = r_scnt + 4'd1;
      if (r_scnt == 4'd15) begin
        w_state = BLANK;
        w_idx   = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        if (w_idx == '0) begin
          w_seg_q  = seg_data;
          w_bright = brightness;
        end
      end else begin
        w_state = (w_scnt <= r_bright) ? ON : OFF;
      end
    end else begin
      w_pcnt = r_pcnt + 1'b1;
    end
    // outputs are registered from next-state values so they line up with the state
    w_dsel = (w_state == ON) ? NUM_DIGITS'(1) << w_idx : '0;
    w_seg  = (w_state == ON) ? r_seg_q[w_idx*SEG_W +: SEG_W] : '0;
    w_fs   = (w_state == BLANK) && (w_idx == '0) && (w_pcnt == '0);
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= IDLE;
      r_pcnt   <= '0;
      r_scnt   <= '0;
      r_idx    <= '0;
      r_seg_q  <= '0;
      r_bright <= '0;
      r_dsel   <= '0;
      r_seg    <= '0;
      r_fs     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pcnt   <= w_pcnt;
      r_scnt   <= w_scnt;
      r_idx    <= w_idx;
      r_seg_q  <= w_seg_q;
      r_bright <= w_bright;
      r_dsel   <= w_dsel;
      r_seg    <= w_seg;
      r_fs     <= w_fs;
    end
  end
  assign digit_sel   = r_dsel;
  assign seg_out     = r_seg;
  assign frame_start = r_fs;
  assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: table-driven frame checks plus disable and async-reset sequences.
module tb_led_scan_ctrl;
  logic        clk = 1'b0;
  logic        rstN;
  logic        enable = 1'b0;
  logic [31:0] seg_data = '0;
  logic [3:0]  brightness = '0;
  logic [3:0]  digit_sel;
  logic [7:0]  seg_out;
  logic        frame_start;
  logic        busy;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  led_scan_ctrl #(.NUM_DIGITS(4), .SEG_W(8), .PRESCALE(2)) dut (
    .clk(clk), .rstN(rstN), .enable(enable), .seg_data(seg_data),
    .brightness(brightness), .digit_sel(digit_sel), .seg_out(seg_out),
    .frame_start(frame_start), .busy(busy)
  );
  typedef struct {
    logic [3:0]  br0;
    logic [31:0] sd0;
    logic [3:0]  br1;
    logic [31:0] sd1;
    int          chg;
    int          on0;
    int          on1;
  } vec_t;
  vec_t v[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] outs();
    return {18'b0, busy, frame_start, digit_sel, seg_out};
  endfunction
  initial begin
    // on-time per slot in clk cycles = 2*brightness; a change at cycle chg lands in frame 1
    v[0] = '{4'd15, 32'h44332211, 4'd15, 32'h44332211, 999, 30, 30};
    v[1] = '{4'd4,  32'h44332211, 4'd4,  32'h44332211, 999, 8,  8};
    v[2] = '{4'd0,  32'h44332211, 4'd0,  32'h44332211, 999, 0,  0};
    v[3] = '{4'd15, 32'h44332211, 4'd4,  32'hAABBCCDD, 40,  30, 8};
    v[4] = '{4'd1,  32'h0F0E0D0C, 4'd8,  32'h11223344, 100, 2,  16};
    rstN = 1'b1;
    #2 rstN = 1'b0;
    #2 chk("reset_outs", outs(), 32'h0);
    tick;
    chk("reset_hold", outs(), 32'h0);
    rstN = 1'b1;
    tick;
    tick;
    chk("idle_no_enable", outs(), 32'h0);
    for (int i = 0; i < 5; i++) begin
      enable = 1'b0;
      brightness = v[i].br0;
      seg_data = v[i].sd0;
      tick;
      chk("vec_idle", outs(), 32'h0);
      enable = 1'b1;
      for (int t = 0; t < 256; t++) begin
        logic [31:0] sd;
        logic [7:0]  byt;
        logic [13:0] e;
        int          slot, off, on_n;
        logic        on;
        tick;
        sd   = (t >= 128) ? v[i].sd1 : v[i].sd0;
        on_n = (t >= 128) ? v[i].on1 : v[i].on0;
        slot = (t % 128) / 32;
        off  = t % 32;
        on   = (off >= 2) && (off < 2 + on_n);
        byt  = sd[slot*8 +: 8];
        e    = {1'b1, (t % 128) == 0, on ? 4'(1 << slot) : 4'b0, on ? byt : 8'h0};
        chk($sformatf("vec%0d_t%0d", i, t), outs(), {18'b0, e});
        if (t == v[i].chg) begin
          brightness = v[i].br1;
          seg_data = v[i].sd1;
        end
      end
    end
    enable = 1'b0;
    brightness = 4'd15;
    seg_data = 32'h44332211;
    tick;
    enable = 1'b1;
    for (int t = 0; t < 70; t++) tick;
    chk("drop_pre_on_d2", outs(), {18'b0, 2'b10, 4'b0100, 8'h33});
    enable = 1'b0;
    tick;
    chk("drop_idle", outs(), 32'h0);
    enable = 1'b1;
    tick;
    chk("reen_frame_start", outs(), {18'b0, 2'b11, 4'b0, 8'h0});
    tick;
    tick;
    chk("reen_first_on", outs(), {18'b0, 2'b10, 4'b0001, 8'h11});
    for (int t = 0; t < 8; t++) tick;
    chk("rst_pre_on", outs(), {18'b0, 2'b10, 4'b0001, 8'h11});
    #2 rstN = 1'b0;
    #1 chk("rst_async_outs", outs(), 32'h0);
    tick;
    chk("rst_held_edge", outs(), 32'h0);
    enable = 1'b0;
    rstN = 1'b1;
    tick;
    tick;
    chk("rst_release_idle", outs(), 32'h0);
    enable = 1'b1;
    tick;
    chk("rst_restart", outs(), {18'b0, 2'b11, 4'b0, 8'h0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
